// File: rtl/traffic_timer.sv
// ----------------------------------------------------------------------------
// traffic_timer
//
// Interval timer that sits beside the traffic-light controller FSM. The
// controller raises the start-request level `sc`; the timer acknowledges it
// with a single-cycle `fb` pulse, restarts its count from zero, and then
// raises `ts` (short / yellow interval done) and `tl` (long / green interval
// done) as the count reaches TS_LIMIT and TL_LIMIT ticks. The count
// saturates at TL_LIMIT, so an idle timer simply parks with ts = tl = 1.
//
// The timer runs straight out of reset. No start request is needed for
// the first interval.
//
// Optional build macro:
//   TIMER_PRESCALE_EN  When defined, a PS_W-bit prescaler divides clk so that
//                      one tick occurs every PRESCALE clk cycles. When not
//                      defined, every clk cycle is a tick and PRESCALE/PS_W
//                      are unused.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous reset, active low
//   sc     in   1      start-count request level, held until fb seen
//   fb     out  1      start acknowledge, one-cycle pulse
//   ts     out  1      short interval elapsed (level, cleared on restart)
//   tl     out  1      long interval elapsed (level, cleared on restart)
//   cnt    out  CNT_W  current tick count (observation only)
// ----------------------------------------------------------------------------

module traffic_timer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TS_LIMIT = 5,
    parameter int unsigned TL_LIMIT = 25,
    parameter int unsigned PS_W     = 26,
    parameter int unsigned PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sc,
    output logic             fb,
    output logic             ts,
    output logic             tl,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] TsLimit = CNT_W'(TS_LIMIT);
    localparam logic [CNT_W-1:0] TlLimit = CNT_W'(TL_LIMIT);

    logic             r_fb;
    logic             r_ts;
    logic             r_tl;
    logic [CNT_W-1:0] r_cnt;

    logic             w_restart;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_next;

    // A request is only honoured while no acknowledge is in flight. On the
    // fb cycle sc is ignored, so a controller that drops sc after seeing fb
    // gets exactly one restart.
    assign w_restart = sc & ~r_fb;

`ifdef TIMER_PRESCALE_EN
    localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_ps;

    assign w_tick = (r_ps == PsLast);

    // The restart also realigns the prescaler, so a fresh interval always
    // lasts whole multiples of PRESCALE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps <= '0;
        end else if (w_restart || w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;

    // The prescaler configuration is meaningless in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{PS_W[0], PRESCALE[0]};
`endif

    // Restart wins over a coincident tick. Counting stops at TL_LIMIT.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_restart) begin
            w_cnt_next = '0;
        end else if (w_tick && (r_cnt < TlLimit)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // ts/tl follow the next count directly. Because the count only climbs
    // until a restart, both behave as sticky flags, and tl implies ts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_fb  <= 1'b0;
            r_ts  <= 1'b0;
            r_tl  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_fb  <= w_restart;
            r_ts  <= (w_cnt_next >= TsLimit);
            r_tl  <= (w_cnt_next >= TlLimit);
        end
    end

    assign fb  = r_fb;
    assign ts  = r_ts;
    assign tl  = r_tl;
    assign cnt = r_cnt;

endmodule

// File: tb/tb_traffic_timer.sv
// ----------------------------------------------------------------------------
// tb_traffic_timer
//
// Directed, table-driven bench for traffic_timer with TS_LIMIT=3, TL_LIMIT=6,
// CNT_W=4 (PRESCALE=4 when TIMER_PRESCALE_EN is defined). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// ----------------------------------------------------------------------------

module tb_traffic_timer;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TS_LIMIT = 3;
    localparam int unsigned TL_LIMIT = 6;
    localparam int unsigned PS_W     = 3;
    localparam int unsigned PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int unsigned RATE = PRESCALE;
`else
    localparam int unsigned RATE = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sc = 1'b0;
    logic             fb;
    logic             ts;
    logic             tl;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sc;
        logic       fb;
        logic       ts;
        logic       tl;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    traffic_timer #(
        .CNT_W    (CNT_W),
        .TS_LIMIT (TS_LIMIT),
        .TL_LIMIT (TL_LIMIT),
        .PS_W     (PS_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sc    (sc),
        .fb    (fb),
        .ts    (ts),
        .tl    (tl),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic e_fb, input logic e_ts,
                         input logic e_tl, input logic [CNT_W-1:0] e_cnt);
        checks++;
        if ({fb, ts, tl, cnt} !== {e_fb, e_ts, e_tl, e_cnt}) begin
            errors++;
            $display("FAIL %s: got fb=%b ts=%b tl=%b cnt=%0d, want fb=%b ts=%b tl=%b cnt=%0d",
                     name, fb, ts, tl, cnt, e_fb, e_ts, e_tl, e_cnt);
        end
    endtask

    task automatic step(input logic s);
        sc = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic f, input logic t_s, input logic t_l,
                       input int c);
        vec_t v;
        v.sc  = s;
        v.fb  = f;
        v.ts  = t_s;
        v.tl  = t_l;
        v.cnt = 4'(c);
        vecs.push_back(v);
    endtask

    // Free-running count after e ticks-worth of clk edges since (re)start.
    function automatic int exp_cnt(input int e);
        int c;
        c = e / int'(RATE);
        return (c > int'(TL_LIMIT)) ? int'(TL_LIMIT) : c;
    endfunction

    initial begin
        int c;

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;

`ifndef TIMER_PRESCALE_EN
        // Free run after reset: ts after edge 3, tl after edge 6, saturate.
        add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 2); add(0, 0, 1, 0, 3);
        add(0, 0, 1, 0, 4); add(0, 0, 1, 0, 5); add(0, 0, 1, 1, 6);
        add(0, 0, 1, 1, 6); add(0, 0, 1, 1, 6);
        // One-cycle sc while saturated.
        add(1, 1, 0, 0, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 3);
        // sc held two cycles: one acknowledge only.
        add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 1); add(0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 3);
        // sc held three cycles: restarts at edges k and k+2.
        add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 1); add(1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 2); add(0, 0, 1, 0, 3);
        add(0, 0, 1, 0, 4);

        foreach (vecs[i]) begin
            step(vecs[i].sc);
            check($sformatf("vec%0d", i), vecs[i].fb, vecs[i].ts, vecs[i].tl, vecs[i].cnt);
        end
`else
        // Prescaled free run: one tick every PRESCALE cycles.
        for (int e = 1; e <= 26; e++) begin
            step(1'b0);
            c = exp_cnt(e);
            check($sformatf("ps_run%0d", e), 1'b0, c >= int'(TS_LIMIT), c >= int'(TL_LIMIT),
                  4'(c));
        end
        // Restart realigns the prescaler.
        step(1'b1);
        check("ps_restart", 1'b1, 1'b0, 1'b0, 4'd0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b0);
            c = exp_cnt(e);
            check($sformatf("ps_after%0d", e), 1'b0, c >= int'(TS_LIMIT), 1'b0, 4'(c));
        end
`endif

        // Asynchronous reset mid-count, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        check("async_hold", 1'b0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 3 * int'(RATE); e++) begin
            step(1'b0);
            c = exp_cnt(e);
            check($sformatf("resume%0d", e), 1'b0, c >= int'(TS_LIMIT), 1'b0, 4'(c));
        end

        // Reset truncates an acknowledge pulse.
        step(1'b1);
        check("fb_pulse", 1'b1, 1'b0, 1'b0, 4'd0);
        sc = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("fb_truncated", 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= int'(RATE); e++) begin
            step(1'b0);
        end
        check("post_rst_tick", 1'b0, 1'b0, 1'b0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
